digit_serial_adder: RTL and testbench

Parametrised digit-serial adder/subtractor. It processes a WIDTH-bit addition DIGIT bits per clock over WIDTH/DIGIT cycles through a start/busy/done handshake. It is the area-reduced successor to the single-bit full adder: it is built from a DIGIT-wide ripple slice and adds subtract mode and signed-overflow detection. It sits in the datapath where throughput can be traded for adder area.

---
 rtl/digit_serial_adder_pkg.sv | 24 ++
 rtl/digit_serial_adder_digit_adder.sv | 45 ++++
 rtl/full_adder.sv | 21 ++
 rtl/digit_serial_adder.sv | 190 +++++++++++++++++++
 tb/tb_digit_serial_adder.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/digit_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// digit_serial_adder_pkg
//
// Shared definitions for the digit-serial adder/subtractor:
//   state_t        - controller state encoding (IDLE, RUN, DONE), 2 bits
//   counter_width  - width of the digit counter for n digit cycles,
//                    max(1, $clog2(n)) so N=1 still gets a 1-bit counter
// ---------------------------------------------------------------------------
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int counter_width(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/digit_serial_adder_digit_adder.sv
// ---------------------------------------------------------------------------
// digit_adder
//
// DIGIT-wide ripple-carry slice built from full_adder instances. This is the
// only arithmetic in the digit-serial adder; its ripple length sets the
// critical path, independent of the full operand width.
//   operand_1, operand_2 - DIGIT-bit operand slices
//   carry_in             - carry into the least-significant bit of the slice
//   sum                  - DIGIT-bit slice result
//   carry_out            - carry out of the slice MSB
//   msb_carry_in         - carry into the slice MSB (used for signed overflow
//                          when this slice holds the word's top bit)
// ---------------------------------------------------------------------------
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] operand_1,
  input  logic [DIGIT-1:0] operand_2,
  input  logic             carry_in,
  output logic [DIGIT-1:0] sum,
  output logic             carry_out,
  output logic             msb_carry_in
);

  // carry[i] is the carry into bit i; carry[DIGIT] leaves the slice.
  logic [DIGIT:0] carry;

  assign carry[0] = carry_in;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
      full_adder u_full_adder (
        .operand_1 (operand_1[gi]),
        .operand_2 (operand_2[gi]),
        .carry_in  (carry[gi]),
        .sum       (sum[gi]),
        .carry_out (carry[gi+1])
      );
    end
  endgenerate

  assign carry_out    = carry[DIGIT];
  assign msb_carry_in = carry[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//
// Single-bit full adder, the building block of the digit ripple slice.
//   operand_1, operand_2 - addend bits
//   carry_in             - incoming carry
//   sum                  - sum bit
//   carry_out            - outgoing carry
// ---------------------------------------------------------------------------
module full_adder (
  input  logic operand_1,
  input  logic operand_2,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = operand_1 ^ operand_2 ^ carry_in;
  assign carry_out = (operand_1 & operand_2) | (carry_in & (operand_1 ^ operand_2));

endmodule

// File: rtl/digit_serial_adder.sv
// ---------------------------------------------------------------------------
// digit_serial_adder
//
// Digit-serial adder/subtractor. A WIDTH-bit operation is processed DIGIT
// bits per clock over N = WIDTH/DIGIT cycles behind a start/busy/done
// handshake. Subtraction is performed as operand_1 + ~operand_2 + 1.
//
// Parameters
//   WIDTH - operand/result width (>= 1)
//   DIGIT - bits per cycle, 1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0
//
// Ports
//   clock      - rising-edge clock
//   reset      - asynchronous active-high reset
//   start      - request, sampled only in IDLE or DONE
//   subtract   - 0: operand_1 + operand_2 + carry_in, 1: operand_1 - operand_2
//   operand_1  - first operand, latched on the accepting edge
//   operand_2  - second operand, latched on the accepting edge
//   carry_in   - carry seed in add mode, ignored when subtracting
//   busy       - high while digits are being processed
//   done       - one-cycle completion pulse
//   sum        - result register
//   carry_out  - carry out of the MSB (1 = no borrow when subtracting)
//   overflow   - two's-complement signed overflow
// ---------------------------------------------------------------------------
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = counter_width(N);
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("digit_serial_adder: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t           state_reg;
  state_t           state_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] op1_reg;
  logic [WIDTH-1:0] op2_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] partial_reg;

  logic             accept;
  logic             last_digit;

  // Slice outputs
  logic [DIGIT-1:0] slice_sum;
  logic             slice_carry;
  logic             slice_msb_carry;

  logic [WIDTH-1:0] partial_next;

  // -------------------------------------------------------------------------
  // Arithmetic slice: least-significant digit of the operand shift registers
  // -------------------------------------------------------------------------
  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .operand_1    (op1_reg[DIGIT-1:0]),
    .operand_2    (op2_reg[DIGIT-1:0]),
    .carry_in     (carry_reg),
    .sum          (slice_sum),
    .carry_out    (slice_carry),
    .msb_carry_in (slice_msb_carry)
  );

  // New digits enter at the top and move down, so after N shifts the first
  // digit sits in the least-significant position. Written as a shift of the
  // concatenation so that DIGIT == WIDTH needs no special case.
  assign partial_next = WIDTH'({slice_sum, partial_reg} >> DIGIT);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    last_digit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // start is deliberately not looked at here
        if (count_reg == LAST_COUNT) begin
          last_digit = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Operand shift registers, running carry, partial sum and digit counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg   <= '0;
      op1_reg     <= '0;
      op2_reg     <= '0;
      carry_reg   <= 1'b0;
      partial_reg <= '0;
    end else if (accept) begin
      count_reg   <= '0;
      op1_reg     <= operand_1;
      // Subtraction as a + ~b + 1: invert b here, seed the carry with 1.
      op2_reg     <= subtract ? ~operand_2 : operand_2;
      carry_reg   <= subtract ? 1'b1 : carry_in;
      partial_reg <= '0;
    end else if (state_reg == RUN) begin
      op1_reg     <= op1_reg >> DIGIT;
      op2_reg     <= op2_reg >> DIGIT;
      carry_reg   <= slice_carry;
      partial_reg <= partial_next;
      // Hold at N-1 rather than wrapping; the counter is cleared on accept.
      if (!last_digit) begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Result registers: loaded only on the completion edge
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (last_digit) begin
      sum       <= partial_next;
      carry_out <= slice_carry;
      // The final slice holds bit WIDTH-1, so its MSB carries give overflow.
      overflow  <= slice_carry ^ slice_msb_carry;
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_digit_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_digit_serial_adder
//
// Three instances of the adder with WIDTH=8: DIGIT=4 (main), DIGIT=8 and
// DIGIT=1. Stimulus pushes the hand-computed result plus the cycle in which
// done must appear into a scoreboard queue; a monitor pops and compares each
// time an instance raises done.
// ---------------------------------------------------------------------------
module tb_digit_serial_adder;

  localparam int W    = 8;
  localparam int NDUT = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [NDUT-1:0]        start_v = '0;
  logic [NDUT-1:0]        sub_v   = '0;
  logic [NDUT-1:0]        cin_v   = '0;
  logic [NDUT-1:0][W-1:0] op1_v   = '0;
  logic [NDUT-1:0][W-1:0] op2_v   = '0;
  logic [NDUT-1:0]        busy_v;
  logic [NDUT-1:0]        done_v;
  logic [NDUT-1:0]        co_v;
  logic [NDUT-1:0]        ov_v;
  logic [NDUT-1:0][W-1:0] sum_v;

  always #5 clock = ~clock;

  function automatic int digit_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 8 : 1);
  endfunction

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      localparam int DG = (gi == 0) ? 4 : ((gi == 1) ? 8 : 1);
      digit_serial_adder #(
        .WIDTH (W),
        .DIGIT (DG)
      ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start_v[gi]),
        .subtract  (sub_v[gi]),
        .operand_1 (op1_v[gi]),
        .operand_2 (op2_v[gi]),
        .carry_in  (cin_v[gi]),
        .busy      (busy_v[gi]),
        .done      (done_v[gi]),
        .sum       (sum_v[gi]),
        .carry_out (co_v[gi]),
        .overflow  (ov_v[gi])
      );
    end
  endgenerate

  typedef struct {
    int         dut;
    logic [7:0] sum;
    logic       co;
    logic       ov;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   busy_cnt [NDUT];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // -------------------------------------------------------------------------
  // Monitor / scoreboard
  // -------------------------------------------------------------------------
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset) begin
      for (int i = 0; i < NDUT; i++) busy_cnt[i] = 0;
    end else begin
      for (int i = 0; i < NDUT; i++) begin
        if (busy_v[i]) busy_cnt[i]++;
        if (done_v[i]) begin
          if (q.size() == 0) begin
            check($sformatf("unexpected_done_dut%0d", i), int'(done_v[i]), 0);
          end else begin
            e = q.pop_front();
            $display("txn dut%0d (DIGIT=%0d): sum=0x%02h carry_out=%0b overflow=%0b busy_cycles=%0d cycle=%0d",
                     i, digit_of(i), sum_v[i], co_v[i], ov_v[i], busy_cnt[i], cyc);
            check("dut_tag",     i,            e.dut);
            check("done_cycle",  cyc,          e.cyc);
            check("sum",         int'(sum_v[i]), int'(e.sum));
            check("carry_out",   int'(co_v[i]),  int'(e.co));
            check("overflow",    int'(ov_v[i]),  int'(e.ov));
            check("busy_cycles", busy_cnt[i],  W / digit_of(i));
          end
          busy_cnt[i] = 0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (called just after a falling edge)
  // -------------------------------------------------------------------------
  task automatic push_exp(input int d, input logic [7:0] es, input logic eco,
                          input logic eov, input int ecyc);
    exp_t e;
    e.dut = d;
    e.sum = es;
    e.co  = eco;
    e.ov  = eov;
    e.cyc = ecyc;
    q.push_back(e);
  endtask

  task automatic issue(input int d, input logic sub, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input logic [7:0] es,
                       input logic eco, input logic eov);
    start_v[d] = 1'b1;
    sub_v[d]   = sub;
    op1_v[d]   = a;
    op2_v[d]   = b;
    cin_v[d]   = ci;
    push_exp(d, es, eco, eov, cyc + 1 + W / digit_of(d));
    @(negedge clock);
    start_v[d] = 1'b0;
    // Other inputs are don't-care after acceptance; scramble them.
    op1_v[d]   = 8'hC3;
    op2_v[d]   = 8'h3C;
    sub_v[d]   = ~sub;
    cin_v[d]   = ~ci;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge clock);
    if (q.size() != 0) begin
      check("scoreboard_drain_timeout", q.size(), 0);
      q.delete();
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},      int'(busy_v[0]), 0);
    check({tag, "_done"},      int'(done_v[0]), 0);
    check({tag, "_sum"},       int'(sum_v[0]),  0);
    check({tag, "_carry_out"}, int'(co_v[0]),   0);
    check({tag, "_overflow"},  int'(ov_v[0]),   0);
  endtask

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int c0;
    repeat (2) @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Add with carry-out
    issue(0, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    drain();

    // Subtract with borrow (carry_in ignored), then signed subtract overflow
    issue(0, 1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    drain();
    issue(0, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    drain();

    // Signed add overflow via carry seed
    issue(0, 1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    drain();

    // Reset in the first RUN cycle: outputs clear, aborted op gives no done
    start_v[0] = 1'b1;
    sub_v[0]   = 1'b0;
    op1_v[0]   = 8'h44;
    op2_v[0]   = 8'h44;
    cin_v[0]   = 1'b0;
    @(negedge clock);
    start_v[0] = 1'b0;
    check("pre_reset_busy", int'(busy_v[0]), 1);
    reset = 1'b1;
    #1;
    check_outputs_zero("mid_run_reset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    issue(0, 1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);
    drain();

    // start pulsed while busy is ignored
    issue(0, 1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    start_v[0] = 1'b1;
    op1_v[0]   = 8'h11;
    op2_v[0]   = 8'h22;
    @(negedge clock);
    start_v[0] = 1'b0;
    drain();

    // Back-to-back: start held through RUN and DONE
    c0         = cyc;
    start_v[0] = 1'b1;
    sub_v[0]   = 1'b0;
    op1_v[0]   = 8'h0F;
    op2_v[0]   = 8'h0F;
    cin_v[0]   = 1'b0;
    push_exp(0, 8'h1E, 1'b0, 1'b0, c0 + 3);
    push_exp(0, 8'h02, 1'b0, 1'b0, c0 + 6);
    @(negedge clock);
    op1_v[0] = 8'h01;
    op2_v[0] = 8'h01;
    repeat (3) @(negedge clock);
    start_v[0] = 1'b0;
    drain();

    // Parameter corners: N=1 and N=8
    issue(1, 1'b0, 8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1, 1'b0);
    drain();
    issue(2, 1'b0, 8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1, 1'b0);
    drain();
    issue(2, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    drain();
    issue(1, 1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
